// File: rtl/buffer_fill_writer_pkg.sv
// ============================================================================
//  Module      : buffer_arbiter_pkg
//  Description : Shared types and helpers for the buffer arbiter "in" side:
//                fill-writer state encoding, info-word field layout and the
//                info-word packing function.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package buffer_arbiter_pkg;

    // Fill-writer control states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_REQ  = 3'd1,
        ST_GET_DONE = 3'd2,
        ST_FILL     = 3'd3,
        ST_PUT_REQ  = 3'd4,
        ST_PUT_DONE = 3'd5
    } fill_state_t;

    // Info-word field layout
    localparam int C_INFO_IDX_LSB   = 0;
    localparam int C_INFO_IDX_WIDTH = 16;
    localparam int C_INFO_LEN_LSB   = 16;
    localparam int C_INFO_LEN_WIDTH = 15;
    localparam int C_INFO_TRUNC_BIT = 31;

    // Build a 32-bit info word; the caller zero-extends idx and len.
    function automatic logic [31:0] pack_info(
        input logic [C_INFO_IDX_WIDTH-1:0] idx,
        input logic [C_INFO_LEN_WIDTH-1:0] len,
        input logic                        trunc
    );
        logic [31:0] info;
        info = '0;
        info[C_INFO_IDX_LSB +: C_INFO_IDX_WIDTH] = idx;
        info[C_INFO_LEN_LSB +: C_INFO_LEN_WIDTH] = len;
        info[C_INFO_TRUNC_BIT]                   = trunc;
        return info;
    endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_fill_writer_if.sv
// ============================================================================
//  Module      : buffer_fill_writer_if
//  Description : Bundle of the fill writer's stream, arbiter get/put,
//                buffer-memory write and status signals. The master modport
//                is the fill writer; the slave modport is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface buffer_fill_writer_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_WORD_WIDTH = 32,
    parameter int C_IDX_WIDTH  = 4,
    parameter int C_BUF_WORDS  = 256
);
    localparam int C_OFS_WIDTH = $clog2(C_BUF_WORDS);

    // Incoming word stream
    logic [C_WORD_WIDTH-1:0]            s_data_i;
    logic                               s_valid_i;
    logic                               s_last_i;
    logic                               s_ready_o;
    // Arbiter in-get port
    logic                               in_info_get_req_o;
    logic                               in_info_get_ack_i;
    logic [C_DATA_WIDTH-1:0]            in_info_get_data_i;
    logic                               in_info_get_overflow_i;
    // Arbiter in-put port
    logic                               in_info_put_req_o;
    logic                               in_info_put_ack_i;
    logic [C_DATA_WIDTH-1:0]            in_info_put_data_o;
    // Buffer memory write port
    logic                               mem_we_o;
    logic [C_IDX_WIDTH+C_OFS_WIDTH-1:0] mem_addr_o;
    logic [C_WORD_WIDTH-1:0]            mem_wdata_o;
    // Status
    logic [15:0]                        frame_cnt_o;
    logic [15:0]                        overflow_cnt_o;
    logic                               busy_o;

    modport master (
        input  s_data_i, s_valid_i, s_last_i,
        output s_ready_o,
        output in_info_get_req_o,
        input  in_info_get_ack_i, in_info_get_data_i, in_info_get_overflow_i,
        output in_info_put_req_o, in_info_put_data_o,
        input  in_info_put_ack_i,
        output mem_we_o, mem_addr_o, mem_wdata_o,
        output frame_cnt_o, overflow_cnt_o, busy_o
    );

    modport slave (
        output s_data_i, s_valid_i, s_last_i,
        input  s_ready_o,
        input  in_info_get_req_o,
        output in_info_get_ack_i, in_info_get_data_i, in_info_get_overflow_i,
        input  in_info_put_req_o, in_info_put_data_o,
        output in_info_put_ack_i,
        input  mem_we_o, mem_addr_o, mem_wdata_o,
        input  frame_cnt_o, overflow_cnt_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/buffer_fill_writer_req_ack_master.sv
// ============================================================================
//  Module      : req_ack_master
//  Description : Four-phase req/ack initiator. A start pulse raises req; the
//                ack cycle drops req; completion is signalled once ack falls.
//                A data register is captured either at start (outgoing data)
//                or in the ack cycle (incoming data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_ack_master #(
    parameter int C_DATA_WIDTH   = 32,
    parameter bit C_LATCH_ON_ACK = 1'b0
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_start,
    input  wire logic [C_DATA_WIDTH-1:0] i_data,
    output logic                         o_req,
    input  wire logic                    i_ack,
    output logic [C_DATA_WIDTH-1:0]      o_data,
    output logic                         o_accept,
    output logic                         o_done
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_REQ  = 2'd1;
    localparam logic [1:0] C_ST_WAIT = 2'd2;

    logic [1:0]              r_state;
    logic [C_DATA_WIDTH-1:0] r_data;
    logic                    w_capture;

    assign o_req    = (r_state == C_ST_REQ);
    assign o_accept = o_req & i_ack;
    assign o_done   = (r_state == C_ST_WAIT) & ~i_ack;
    assign o_data   = r_data;

    generate
        if (C_LATCH_ON_ACK) begin : g_latch_ack
            assign w_capture = o_accept;
        end else begin : g_latch_start
            assign w_capture = i_start & (r_state == C_ST_IDLE);
        end
    endgenerate

    // Handshake phase tracking: idle -> req high -> wait for ack release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            case (r_state)
                C_ST_IDLE: if (i_start) r_state <= C_ST_REQ;
                C_ST_REQ:  if (i_ack)   r_state <= C_ST_WAIT;
                C_ST_WAIT: if (!i_ack)  r_state <= C_ST_IDLE;
                default:                r_state <= C_ST_IDLE;
            endcase
        end
    end

    // Data register, held stable between captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_capture) begin
            r_data <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/buffer_fill_writer.sv
// ============================================================================
//  Module      : buffer_fill_writer
//  Description : Producer side of the buffer arbiter. Prefetches a free
//                buffer index, writes the incoming word stream into buffer
//                memory at {index, offset}, and returns the filled buffer
//                with its length and truncation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer_fill_writer
    import buffer_arbiter_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_WORD_WIDTH = 32,
    parameter int C_IDX_WIDTH  = 4,
    parameter int C_BUF_WORDS  = 256
) (
    input wire logic              clk,
    input wire logic              rst,
    buffer_fill_writer_if.master  bus
);

    localparam int C_OFS_WIDTH = $clog2(C_BUF_WORDS);
    localparam int C_LEN_WIDTH = C_OFS_WIDTH + 1;

    fill_state_t                        r_state;
    logic [C_OFS_WIDTH-1:0]             r_offset;
    logic [15:0]                        r_frame_cnt;
    logic [15:0]                        r_overflow_cnt;
    logic                               r_mem_we;
    logic [C_IDX_WIDTH+C_OFS_WIDTH-1:0] r_mem_addr;
    logic [C_WORD_WIDTH-1:0]            r_mem_wdata;

    logic [C_IDX_WIDTH-1:0]             w_index;
    logic                               w_beat;
    logic                               w_full;
    logic                               w_close;
    logic                               w_trunc;
    logic [C_LEN_WIDTH-1:0]             w_len;
    logic [C_DATA_WIDTH-1:0]            w_info;
    logic                               w_get_start;
    logic                               w_get_accept;
    logic                               w_get_done;
    logic                               w_put_accept;
    logic                               w_put_done;

    assign w_beat  = (r_state == ST_FILL) & bus.s_valid_i;
    assign w_full  = &r_offset;
    assign w_close = w_beat & (bus.s_last_i | w_full);
    // A last word landing exactly on the final slot still ends the frame.
    assign w_trunc = w_full & ~bus.s_last_i;
    assign w_len   = {1'b0, r_offset} + C_LEN_WIDTH'(1);
    assign w_info  = C_DATA_WIDTH'(pack_info(16'(w_index), 15'(w_len), w_trunc));

    // The next get starts straight out of reset and after every completed put.
    assign w_get_start = (r_state == ST_IDLE) | ((r_state == ST_PUT_DONE) & w_put_done);

    req_ack_master #(
        .C_DATA_WIDTH   (C_IDX_WIDTH),
        .C_LATCH_ON_ACK (1'b1)
    ) u_get (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_get_start),
        .i_data   (bus.in_info_get_data_i[C_IDX_WIDTH-1:0]),
        .o_req    (bus.in_info_get_req_o),
        .i_ack    (bus.in_info_get_ack_i),
        .o_data   (w_index),
        .o_accept (w_get_accept),
        .o_done   (w_get_done)
    );

    req_ack_master #(
        .C_DATA_WIDTH   (C_DATA_WIDTH),
        .C_LATCH_ON_ACK (1'b0)
    ) u_put (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_close),
        .i_data   (w_info),
        .o_req    (bus.in_info_put_req_o),
        .i_ack    (bus.in_info_put_ack_i),
        .o_data   (bus.in_info_put_data_o),
        .o_accept (w_put_accept),
        .o_done   (w_put_done)
    );

    // Main control: get index, fill buffer, put buffer, repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_offset       <= '0;
            r_frame_cnt    <= '0;
            r_overflow_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_GET_REQ;
                end
                ST_GET_REQ: begin
                    if (w_get_accept) begin
                        r_state <= ST_GET_DONE;
                        if (bus.in_info_get_overflow_i && (r_overflow_cnt != 16'hFFFF)) begin
                            r_overflow_cnt <= r_overflow_cnt + 16'd1;
                        end
                    end
                end
                ST_GET_DONE: begin
                    if (w_get_done) begin
                        r_state  <= ST_FILL;
                        r_offset <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_beat) begin
                        r_offset <= r_offset + C_OFS_WIDTH'(1);
                        if (w_close) begin
                            r_state <= ST_PUT_REQ;
                        end
                    end
                end
                ST_PUT_REQ: begin
                    if (w_put_accept) begin
                        r_state     <= ST_PUT_DONE;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_PUT_DONE: begin
                    if (w_put_done) begin
                        r_state <= ST_GET_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer memory write, one cycle after each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_beat;
            if (w_beat) begin
                r_mem_addr  <= {w_index, r_offset};
                r_mem_wdata <= bus.s_data_i;
            end
        end
    end

    assign bus.s_ready_o      = (r_state == ST_FILL);
    assign bus.busy_o         = (r_state != ST_IDLE);
    assign bus.frame_cnt_o    = r_frame_cnt;
    assign bus.overflow_cnt_o = r_overflow_cnt;
    assign bus.mem_we_o       = r_mem_we;
    assign bus.mem_addr_o     = r_mem_addr;
    assign bus.mem_wdata_o    = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_buffer_fill_writer.sv
// ============================================================================
//  Module      : tb_buffer_fill_writer
//  Description : Self-checking bench for buffer_fill_writer with 4-word
//                buffers. Arbiter get/put responders and a memory-write
//                monitor run alongside a table-driven stream driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffer_fill_writer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    buffer_fill_writer_if #(
        .C_DATA_WIDTH (32), .C_WORD_WIDTH (32), .C_IDX_WIDTH (4), .C_BUF_WORDS (4)
    ) bus ();

    buffer_fill_writer #(
        .C_DATA_WIDTH (32), .C_WORD_WIDTH (32), .C_IDX_WIDTH (4), .C_BUF_WORDS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  idx;
        bit          ov;
        int          gdelay;
        int          nwords;
        bit          last;
        int          pdelay;
        logic [31:0] dbase;
        logic [31:0] exp_put;
        int          exp_frames;
        int          exp_ovf;
    } entry_t;

    typedef struct { logic [3:0] idx; bit ov; int delay; int exp_ovf; } grant_t;
    typedef struct { logic [31:0] data; int delay; int exp_frames; }      put_t;
    typedef struct { logic [5:0] addr; logic [31:0] data; }               wr_t;

    grant_t gq[$];
    put_t   pq[$];
    wr_t    wq[$];
    entry_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Arbiter in-get side: grants popped from gq, four-phase handshake
    task automatic get_responder();
        grant_t g;
        int     c0;
        int     n;
        forever begin
            @(negedge clk);
            if (!rst && bus.in_info_get_req_o && gq.size() > 0) begin
                g  = gq.pop_front();
                c0 = cyc;
                repeat (g.delay - 1) @(posedge clk);
                #1;
                bus.in_info_get_ack_i      = 1'b1;
                bus.in_info_get_data_i     = {28'd0, g.idx};
                bus.in_info_get_overflow_i = g.ov;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (bus.in_info_get_req_o && n < 50);
                check("get_req_held", 32'(cyc - c0), 32'(g.delay));
                check("overflow_cnt", 32'(bus.overflow_cnt_o), 32'(g.exp_ovf));
                @(posedge clk);
                #1;
                bus.in_info_get_ack_i      = 1'b0;
                bus.in_info_get_data_i     = '0;
                bus.in_info_get_overflow_i = 1'b0;
                @(negedge clk);
                check("rdy_before_fill", 32'(bus.s_ready_o), 32'd0);
                @(negedge clk);
                check("rdy_latency", 32'(bus.s_ready_o), 32'd1);
            end
        end
    endtask

    // Arbiter in-put side: compares the info word, optionally delays the ack
    task automatic put_responder();
        put_t p;
        int   viol;
        int   n;
        forever begin
            @(negedge clk);
            if (!rst && bus.in_info_put_req_o && pq.size() > 0) begin
                p = pq.pop_front();
                check("put_data", bus.in_info_put_data_o, p.data);
                viol = bus.s_ready_o ? 1 : 0;
                for (int c = 1; c < p.delay; c++) begin
                    @(negedge clk);
                    if (bus.s_ready_o || bus.mem_we_o || bus.in_info_put_data_o !== p.data) viol++;
                end
                @(posedge clk);
                #1;
                bus.in_info_put_ack_i = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (bus.in_info_put_req_o && n < 50);
                check("put_stall_quiet", 32'(viol), 32'd0);
                check("frame_cnt", 32'(bus.frame_cnt_o), 32'(p.exp_frames));
                @(posedge clk);
                #1;
                bus.in_info_put_ack_i = 1'b0;
            end
        end
    endtask

    // Every memory write must match the next expected {addr, data}
    task automatic mem_monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_we_o) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_write: unexpected write addr 0x%02h data 0x%08h, required none",
                             bus.mem_addr_o, bus.mem_wdata_o);
                end else begin
                    w = wq.pop_front();
                    check("mem_addr", 32'(bus.mem_addr_o), 32'(w.addr));
                    check("mem_wdata", bus.mem_wdata_o, w.data);
                end
            end
        end
    endtask

    // Present one word and hold it until the DUT accepts it
    task automatic send_word(input logic [31:0] data, input bit last, input bit push, input logic [5:0] addr);
        int n;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = data;
        bus.s_last_i  = last;
        if (push) wq.push_back('{addr, data});
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready_o) break;
            n++;
            if (n >= 150) begin
                checks++;
                errors++;
                $display("FAIL send_word: timeout, ready 0 required 1");
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Wait until all expectations are consumed and the DUT waits for a grant
    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(wq.size() == 0 && pq.size() == 0 && gq.size() == 0 && bus.in_info_get_req_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(wq.size() + pq.size() + gq.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.s_data_i = '0;  bus.s_valid_i = 1'b0;  bus.s_last_i = 1'b0;
        bus.in_info_get_ack_i = 1'b0;  bus.in_info_get_data_i = '0;
        bus.in_info_get_overflow_i = 1'b0;  bus.in_info_put_ack_i = 1'b0;

        //           idx    ov gdly n  last pdly dbase         exp_put       frm ovf
        tbl[0] = '{4'h5, 1'b0, 3, 2, 1'b1, 1,  32'h0000_000A, 32'h0002_0005, 1, 0};
        tbl[1] = '{4'h3, 1'b0, 1, 4, 1'b0, 2,  32'h0000_0100, 32'h8004_0003, 2, 0};
        tbl[2] = '{4'h7, 1'b0, 2, 2, 1'b1, 1,  32'h0000_0104, 32'h0002_0007, 3, 0};
        tbl[3] = '{4'h2, 1'b1, 1, 3, 1'b1, 1,  32'h0000_0200, 32'h0003_0002, 4, 1};
        tbl[4] = '{4'hF, 1'b0, 2, 4, 1'b1, 10, 32'h0000_0300, 32'h0004_000F, 5, 1};
        tbl[5] = '{4'h1, 1'b0, 1, 1, 1'b1, 1,  32'h0000_0400, 32'h0001_0001, 6, 1};

        fork
            get_responder();
            put_responder();
            mem_monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    32'(bus.s_ready_o), 32'd0);
        check("rst_get_req",  32'(bus.in_info_get_req_o), 32'd0);
        check("rst_put_req",  32'(bus.in_info_put_req_o), 32'd0);
        check("rst_put_data", bus.in_info_put_data_o, 32'd0);
        check("rst_mem_we",   32'(bus.mem_we_o), 32'd0);
        check("rst_frames",   32'(bus.frame_cnt_o), 32'd0);
        check("rst_ovf",      32'(bus.overflow_cnt_o), 32'd0);
        check("rst_busy",     32'(bus.busy_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            gq.push_back('{tbl[i].idx, tbl[i].ov, tbl[i].gdelay, tbl[i].exp_ovf});
            pq.push_back('{tbl[i].exp_put, tbl[i].pdelay, tbl[i].exp_frames});
        end

        rst = 1'b0;
        @(negedge clk);
        check("idle_busy",    32'(bus.busy_o), 32'd0);
        check("idle_get_req", 32'(bus.in_info_get_req_o), 32'd0);
        @(negedge clk);
        check("prefetch_get_req", 32'(bus.in_info_get_req_o), 32'd1);
        check("prefetch_busy",    32'(bus.busy_o), 32'd1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tbl[i].nwords; k++) begin
                send_word(tbl[i].dbase + 32'(k), (k == tbl[i].nwords - 1) && tbl[i].last,
                          1'b1, {tbl[i].idx, 2'(k)});
            end
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        drain("table_drain");
        check("final_frames", 32'(bus.frame_cnt_o), 32'd6);
        check("final_ovf",    32'(bus.overflow_cnt_o), 32'd1);

        // Reset while filling: the single accepted word must never be written
        gq.push_back('{4'h9, 1'b0, 2, 1});
        send_word(32'h0000_0055, 1'b0, 1'b0, 6'd0);
        rst = 1'b1;
        bus.s_valid_i = 1'b0;
        #1;
        check("arst_ready",    32'(bus.s_ready_o), 32'd0);
        check("arst_mem_we",   32'(bus.mem_we_o), 32'd0);
        check("arst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        check("arst_put_data", bus.in_info_put_data_o, 32'd0);
        check("arst_frames",   32'(bus.frame_cnt_o), 32'd0);
        check("arst_ovf",      32'(bus.overflow_cnt_o), 32'd0);
        check("arst_busy",     32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gq.push_back('{4'hA, 1'b0, 1, 0});
        pq.push_back('{32'h0001_000A, 1, 1});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_info_get_req_o && n < 5);
        check("get_req_after_rst", 32'(bus.in_info_get_req_o), 32'd1);
        send_word(32'h0000_0077, 1'b1, 1'b1, {4'hA, 2'd0});
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        drain("rst_drain");
        check("rst_frames_after", 32'(bus.frame_cnt_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/buffer_fill_writer.md
Name: buffer_fill_writer

Overview:
- Upstream producer stage of the buffer arbiter's "in" side.
- Obtains a free buffer index through the arbiter's in-get req/ack port.
- Writes an incoming valid/ready word stream into the shared buffer memory at {index, offset}.
- Returns the filled buffer, with its length, through the arbiter's in-put req/ack port so the consumer side can fetch it from the exist queue.

Parameters:
C_DATA_WIDTH, 32, width of arbiter info words (get/put data)
C_WORD_WIDTH, 32, stream and memory data width
C_IDX_WIDTH, 4, buffer index width (buffer depth 16)
C_BUF_WORDS, 256, words per buffer; power of two, >=2
C_OFS_WIDTH, clog2(C_BUF_WORDS), offset width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_data_i  in  C_WORD_WIDTH  stream word
s_valid_i  in  1  stream word valid
s_last_i  in  1  last word of frame
s_ready_o  out  1  stream ready
in_info_get_req_o  out  1  request free buffer index
in_info_get_ack_i  in  1  arbiter grant
in_info_get_data_i  in  C_DATA_WIDTH  granted info; index in [C_IDX_WIDTH-1:0]
in_info_get_overflow_i  in  1  grant recycled a not-yet-consumed buffer
in_info_put_req_o  out  1  return filled buffer
in_info_put_ack_i  in  1  arbiter accepted put
in_info_put_data_o  out  C_DATA_WIDTH  filled-buffer info word
mem_we_o  out  1  buffer memory write enable
mem_addr_o  out  C_IDX_WIDTH+C_OFS_WIDTH  {index, offset}
mem_wdata_o  out  C_WORD_WIDTH  write data
frame_cnt_o  out  16  buffers returned (wraps)
overflow_cnt_o  out  16  grants with overflow flag (saturates at 0xFFFF)
busy_o  out  1  high whenever state != IDLE

Behaviour:
Reset values:
- All outputs 0; state IDLE; index and offset registers 0.
- Reset is asynchronous mid-operation. Any held index is abandoned; the arbiter must be reset in the same domain.

State machine:
- IDLE -> GET_REQ: unconditionally one cycle after reset release. Buffers are prefetched, so an index is held before data arrives.
- GET_REQ: req_o=1. When ack_i=1, latch index = data_i[C_IDX_WIDTH-1:0] and drop req next cycle.
  - If overflow_i=1 in the ack cycle, increment overflow_cnt.
  - Go to GET_DONE.
- GET_DONE: wait ack_i=0 (four-phase), then go to FILL with offset=0.
- FILL: s_ready_o=1. Each beat (valid&ready) is written and offset increments.
  - Close on a beat with s_last_i=1, or on the beat where offset==C_BUF_WORDS-1.
  - Closing latches len = offset+1 (width C_OFS_WIDTH+1) and the trunc flag, then goes to PUT_REQ.
- PUT_REQ: put_req_o=1, s_ready_o=0. put_data_o is held stable until ack.
  - On ack_i=1, increment frame_cnt, drop req next cycle, go to PUT_DONE.
- PUT_DONE: wait ack_i=0, then go to GET_REQ.

Info word format (put_data_o):
- [C_IDX_WIDTH-1:0] = index.
- [30:16] = len, zero-extended.
- [31] = trunc. trunc is 1 when the buffer filled without s_last_i; the remaining frame words continue into the next buffer.
- All other bits 0.

Memory write:
- Registered, 1-cycle latency after the beat.
- mem_addr_o = {index, offset-at-beat}.
- No write occurs outside FILL.

Stream and handshake rules:
- s_ready_o is low in every state except FILL. Valid words stall upstream; no word is ever dropped.
- If s_last_i=1 on the full-buffer beat, trunc=0.
- A single-word frame gives len=1.
- Empty frames are impossible: s_last_i is only sampled with valid.
- Counters wrap or saturate exactly as stated; there are no other arithmetic overflows.
- Get ack arriving while in FILL or PUT_* states is ignored.

Decomposition:
- Package buffer_arbiter_pkg holds:
  - the state enum;
  - info-word field localparams (IDX lsb, LEN lsb 16, LEN width 15, TRUNC bit 31);
  - function pack_info(idx, len, trunc).
- One sub-module, req_ack_master (four-phase req/ack initiator with data latch), instantiated twice: get side and put side.

Test Plan:
All scenarios use C_BUF_WORDS=4 and C_IDX_WIDTH=4.
- Reset, arbiter grants idx 5 after 3 cycles -> req held 3 cycles; s_ready_o rises 2 cycles after ack falls; overflow_cnt=0.
- Frame of 2 words (0xA,0xB, last on 2nd), idx 5 -> mem writes at addr 0x14=0xA and 0x15=0xB; put_data=0x0002_0005; frame_cnt=1.
- Frame of 6 words, grants 3 then 7 -> puts 0x8004_0003 then 0x0002_0007; writes at 0x0C..0x0F then 0x1C..0x1D.
- Grant idx 2 with overflow=1 -> overflow_cnt=1; normal fill continues.
- s_valid held high with put_ack delayed 10 cycles -> s_ready_o=0 throughout; no mem_we; no word lost.
- Assert rst during FILL after 1 word -> all outputs 0 immediately; after release a new get_req is issued; offset restarts at 0.
